// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver FSM encoding and the oversampling ratio.
package uart_pkg;

   localparam int OVS      = 16;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; the head entry is always visible on
// rdata_o and is dropped (drop_o) when a push arrives while full with no pop.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             empty;
   logic             full;
   logic             do_pop;
   logic             do_push;

   // The extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty;
   assign do_push = push_i & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
            mem_q[gi] <= wdata_i;
         end
      end
   end

   assign rdata_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = empty;
   assign drop_o  = push_i & full & ~do_pop;

endmodule

// File: rtl/uart_rx_cfg.sv
// 16x oversampling UART receiver with configurable data width, parity and
// stop bits; received words and their error flags queue in a FWFT FIFO.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 rx_ready,
   output logic                 overrun
);

   localparam int OVS_DIV = (CLK_HZ + (OVS / 2) * BAUD) / (OVS * BAUD);
   localparam int DIV_W   = $clog2(OVS_DIV + 1);
   localparam int BIT_W   = $clog2(DATA_BITS);
   localparam int FIFO_W  = DATA_BITS + 2;

   logic             rx_meta_q;
   logic             rx_sync_q;
   logic             rx_prev_q;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             tick;

   rx_state_e              state_q, state_d;
   logic [3:0]             tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [1:0]             samp_q, samp_d;
   logic                   par_err_q, par_err_d;
   logic                   frm_err_q, frm_err_d;

   logic                   start_det;
   logic                   mid_tick;
   logic                   end_tick;
   logic                   vote;
   logic                   push;
   logic                   push_frm_err;
   logic [FIFO_W-1:0]      push_word;
   logic [FIFO_W-1:0]      head_word;
   logic                   fifo_empty;
   logic                   fifo_drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign start_det = (state_q == ST_IDLE) && rx_prev_q && !rx_sync_q;

   // The divider restarts on the start edge so the tick phase is locked to the frame.
   assign tick = (div_cnt_q == DIV_W'(OVS_DIV - 1));

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      if (start_det || tick) begin
         div_cnt_d = '0;
      end
   end

   assign mid_tick = tick && (tick_cnt_q == 4'd9);
   assign end_tick = tick && (tick_cnt_q == 4'd15);
   assign vote     = majority3(samp_q[0], samp_q[1], rx_sync_q);

   assign push_frm_err = frm_err_q | ~vote;
   assign push_word    = {shift_q, par_err_q, push_frm_err};

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      samp_d     = samp_q;
      par_err_d  = par_err_q;
      frm_err_d  = frm_err_q;
      push       = 1'b0;

      if (tick && (tick_cnt_q == 4'd7)) begin
         samp_d[0] = rx_sync_q;
      end
      if (tick && (tick_cnt_q == 4'd8)) begin
         samp_d[1] = rx_sync_q;
      end

      unique case (state_q)
         ST_IDLE: begin
            tick_cnt_d = '0;
            if (start_det) begin
               state_d    = ST_START;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               par_err_d  = 1'b0;
               frm_err_d  = 1'b0;
            end
         end

         ST_START: begin
            if (mid_tick && vote) begin
               state_d = ST_IDLE;
            end else if (end_tick) begin
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (mid_tick) begin
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
            end
            if (end_tick) begin
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         ST_PARITY: begin
            // Error when the ones count (data plus parity bit) has the wrong polarity.
            if (mid_tick) begin
               if (PARITY == PAR_ODD) begin
                  par_err_d = ~(^shift_q ^ vote);
               end else begin
                  par_err_d = ^shift_q ^ vote;
               end
            end
            if (end_tick) begin
               state_d = ST_STOP;
            end
         end

         ST_STOP: begin
            if (mid_tick) begin
               if (!vote) begin
                  frm_err_d = 1'b1;
               end
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  push    = 1'b1;
                  state_d = vote ? ST_IDLE : ST_WAIT_IDLE;
               end
            end else if (end_tick) begin
               stop_cnt_d = 1'b1;
            end
         end

         ST_WAIT_IDLE: begin
            tick_cnt_d = '0;
            if (rx_sync_q) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q  <= '0;
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         samp_q     <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         samp_q     <= samp_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
      end
   end

   uart_rx_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .wdata_i (push_word),
      .pop_i   (rd_en),
      .rdata_o (head_word),
      .empty_o (fifo_empty),
      .drop_o  (fifo_drop)
   );

   assign data_out   = head_word[FIFO_W-1:2];
   assign parity_err = head_word[1];
   assign frame_err  = head_word[0];
   assign rx_ready   = ~fifo_empty;
   assign overrun    = fifo_drop;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a default 8N1 instance and an 8E2 instance
// driven with hand-built frames at 115200 baud on a 50 MHz clock.
module tb_uart_rx_cfg;

   localparam int BIT_T = 8680;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx0   = 1'b1;
   logic       rx1   = 1'b1;
   logic       rd0   = 1'b0;
   logic       rd1   = 1'b0;
   logic [7:0] dout0, dout1;
   logic       pe0, fe0, rdy0, ovr0;
   logic       pe1, fe1, rdy1, ovr1;

   int errors   = 0;
   int checks   = 0;
   int ovr_cnt0 = 0;
   int ovr_cnt1 = 0;

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (ovr0) ovr_cnt0++;
      if (ovr1) ovr_cnt1++;
   end

   uart_rx_cfg dut0 (
      .clk(clk), .reset(reset), .rx(rx0), .rd_en(rd0),
      .data_out(dout0), .parity_err(pe0), .frame_err(fe0),
      .rx_ready(rdy0), .overrun(ovr0)
   );

   uart_rx_cfg #(.PARITY(2), .STOP_BITS(2)) dut1 (
      .clk(clk), .reset(reset), .rx(rx1), .rd_en(rd1),
      .data_out(dout1), .parity_err(pe1), .frame_err(fe1),
      .rx_ready(rdy1), .overrun(ovr1)
   );

   task automatic line_bits(input int sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel == 0) rx0 = bits[i];
         else          rx1 = bits[i];
         #(BIT_T);
      end
   endtask

   task automatic send0(input logic [7:0] d, input logic stop);
      logic [15:0] f;
      f = {6'h3F, stop, d, 1'b0};
      line_bits(0, f, 10);
   endtask

   task automatic send1(input logic [7:0] d, input logic par, input logic stop2);
      logic [15:0] f;
      f = {4'hF, stop2, 1'b1, par, d, 1'b0};
      line_bits(1, f, 12);
   endtask

   task automatic pop0();
      @(negedge clk); rd0 = 1'b1;
      @(negedge clk); rd0 = 1'b0;
   endtask

   task automatic pop1();
      @(negedge clk); rd1 = 1'b1;
      @(negedge clk); rd1 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({dout0, pe0, fe0, rdy0, ovr0} !== 12'h000) begin
         errors++;
         $display("FAIL reset_dut0: got data=%h pe=%b fe=%b rdy=%b ovr=%b, expected all 0", dout0, pe0, fe0, rdy0, ovr0);
      end
      checks++;
      if ({dout1, pe1, fe1, rdy1, ovr1} !== 12'h000) begin
         errors++;
         $display("FAIL reset_dut1: got data=%h pe=%b fe=%b rdy=%b ovr=%b, expected all 0", dout1, pe1, fe1, rdy1, ovr1);
      end
      reset = 1'b0;
      rd0 = 1'b1;
      repeat (5) @(negedge clk);
      rd0 = 1'b0;
      checks++;
      if ({rdy0, dout0} !== 9'h000) begin
         errors++;
         $display("FAIL pop_empty: got rdy=%b data=%h, expected 0 00", rdy0, dout0);
      end
   endtask

   task automatic test_basic();
      line_bits(0, 16'h014A, 9);
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_early: got rdy=%b before stop bit, expected 0", rdy0);
      end
      line_bits(0, 16'h0001, 1);
      @(negedge clk);
      checks++;
      if ({rdy0, dout0, pe0, fe0} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_word: got rdy=%b data=%h pe=%b fe=%b, expected 1 a5 0 0", rdy0, dout0, pe0, fe0);
      end
      pop0();
      checks++;
      if (rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_pop: got rdy=%b, expected 0", rdy0);
      end
   endtask

   task automatic test_parity();
      send1(8'h3C, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdy1, dout1, pe1, fe1} !== {1'b1, 8'h3C, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL parity_bad: got rdy=%b data=%h pe=%b fe=%b, expected 1 3c 1 0", rdy1, dout1, pe1, fe1);
      end
      pop1();
      checks++;
      if (rdy1 !== 1'b0) begin
         errors++;
         $display("FAIL parity_pop: got rdy=%b, expected 0", rdy1);
      end
      send1(8'h3C, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdy1, dout1, pe1, fe1} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL parity_good: got rdy=%b data=%h pe=%b fe=%b, expected 1 3c 0 0", rdy1, dout1, pe1, fe1);
      end
      pop1();
      send1(8'hC3, 1'b0, 1'b0);
      rx1 = 1'b1;
      #(BIT_T);
      checks++;
      if ({rdy1, dout1, pe1, fe1} !== {1'b1, 8'hC3, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL stop2_frame: got rdy=%b data=%h pe=%b fe=%b, expected 1 c3 0 1", rdy1, dout1, pe1, fe1);
      end
      pop1();
      checks++;
      if ({rdy1, ovr_cnt1} !== {1'b0, 32'd0}) begin
         errors++;
         $display("FAIL dut1_clean: got rdy=%b overruns=%0d, expected 0 0", rdy1, ovr_cnt1);
      end
   endtask

   task automatic test_framing();
      send0(8'h55, 1'b0);
      #(3 * BIT_T);
      rx0 = 1'b1;
      #(2 * BIT_T);
      checks++;
      if ({rdy0, dout0, pe0, fe0} !== {1'b1, 8'h55, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL frame_word: got rdy=%b data=%h pe=%b fe=%b, expected 1 55 0 1", rdy0, dout0, pe0, fe0);
      end
      pop0();
      checks++;
      if (rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL frame_single: got rdy=%b after one pop, expected 0", rdy0);
      end
   endtask

   task automatic test_false_start();
      rx0 = 1'b0;
      #200;
      rx0 = 1'b1;
      #(2 * BIT_T);
      checks++;
      if (rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL glitch_nopush: got rdy=%b, expected 0", rdy0);
      end
      send0(8'hA5, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdy0, dout0, pe0, fe0} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL glitch_next: got rdy=%b data=%h pe=%b fe=%b, expected 1 a5 0 0", rdy0, dout0, pe0, fe0);
      end
      pop0();
   endtask

   task automatic test_overrun();
      int base;
      base = ovr_cnt0;
      for (int i = 1; i <= 5; i++) begin
         send0(8'(i), 1'b1);
      end
      #(BIT_T);
      checks++;
      if (ovr_cnt0 - base !== 1) begin
         errors++;
         $display("FAIL overrun_count: got %0d pulses, expected 1", ovr_cnt0 - base);
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if ({rdy0, dout0, fe0} !== {1'b1, 8'(i), 1'b0}) begin
            errors++;
            $display("FAIL overrun_pop%0d: got rdy=%b data=%h fe=%b, expected 1 %h 0", i, rdy0, dout0, fe0, 8'(i));
         end
         pop0();
      end
      checks++;
      if (rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL overrun_empty: got rdy=%b, expected 0", rdy0);
      end
   endtask

   task automatic test_reset_midframe();
      int base;
      base = ovr_cnt0;
      line_bits(0, 16'h000A, 5);
      rx0 = 1'b0;
      #(BIT_T / 2);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({dout0, pe0, fe0, rdy0, ovr0} !== 12'h000) begin
         errors++;
         $display("FAIL midreset_out: got data=%h pe=%b fe=%b rdy=%b ovr=%b, expected all 0", dout0, pe0, fe0, rdy0, ovr0);
      end
      reset = 1'b0;
      rx0 = 1'b1;
      #(6 * BIT_T);
      checks++;
      if ({rdy0, 32'(ovr_cnt0 - base)} !== {1'b0, 32'd0}) begin
         errors++;
         $display("FAIL midreset_nopush: got rdy=%b overruns=%0d, expected 0 0", rdy0, ovr_cnt0 - base);
      end
      send0(8'h3C, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdy0, dout0, pe0, fe0} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midreset_next: got rdy=%b data=%h pe=%b fe=%b, expected 1 3c 0 0", rdy0, dout0, pe0, fe0);
      end
      pop0();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_false_start();
      test_overrun();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8N1 receiver on the host serial link. It oversamples the line at 16x with majority voting and rejects false start bits. Data width, parity and stop-bit count are configurable, and parity and framing errors are flagged per word. Received words are buffered in a small first-word-fall-through FIFO with an explicit pop handshake, so the miner control logic can absorb bursts without losing bytes.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame, 1 or 2
- FIFO_DEPTH, 4, receive FIFO entries, power of two, minimum 2

- clk  in  1  system clock; one clock domain only
- reset  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial line, idles high
- rd_en  in  1  pop request; ignored when rx_ready=0
- data_out  out  DATA_BITS  word at the FIFO head, valid while rx_ready=1
- parity_err  out  1  parity error flag of the head word; 0 when PARITY=0
- frame_err  out  1  framing error flag of the head word
- rx_ready  out  1  FIFO not empty
- overrun  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full

## Operation
- rx passes through a 2-FF synchronizer; both flops reset to 1.
- Oversample tick fires every OVS_DIV = (CLK_HZ + 8·BAUD)/(16·BAUD) clocks (integer division). Defaults give 27.
- Bit sample at each bit: majority of ticks 7, 8 and 9 out of 0..15.
- FSM states and transitions:
  - IDLE → START on a synchronized falling edge; tick counter cleared.
  - START: if the voted start bit is 1 (false start) → IDLE; otherwise → DATA.
  - DATA: shift DATA_BITS bits LSB first → PARITY if PARITY≠0, else → STOP.
  - PARITY: capture the parity bit; parity_err = computed ≠ expected (odd: total count of ones including the parity bit is odd; even: it is even).
  - STOP: check each stop bit. A voted 0 on any stop bit sets frame_err. The word plus both flags is pushed at the mid-sample of the last stop bit. Then → IDLE if the sample was 1, else → WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized rx = 1, so a break does not retrigger reception; then → IDLE.
- A word with errors is still pushed; the flags travel with it through the FIFO.
- FIFO full at push time with no simultaneous pop: word dropped, overrun pulses 1 cycle, FIFO contents unchanged.
- Push and pop in the same cycle while full: both take effect, no overrun.
- Push and pop in the same cycle while holding one entry: the new word becomes the head, rx_ready stays 1.
- rd_en while empty: no effect; pointers do not move.
- Pointer wrap-around is handled with one extra pointer bit (full/empty distinction).

## Timing
- Reset values: data_out=0, parity_err=0, frame_err=0, rx_ready=0, overrun=0. FSM in IDLE, FIFO empty, all counters 0.
- Reset mid-frame abandons the frame; nothing is pushed.
- Input latency: 2 clk synchronizer plus up to 1 tick of edge detection.
- Push occurs about 0.5 bit after the start of the last stop bit.
- rx_ready and the head outputs update the clock after a push into an empty FIFO.
- Pop: on rising clk with rd_en=1 and rx_ready=1, the head advances; next word (or rx_ready=0) appears on the following cycle.
- overrun is asserted for the same cycle the dropped push would have occurred.
- Back-to-back frames: the next start edge is accepted from IDLE immediately after push.

## Structure
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
  - oversample ratio constant OVS=16
- One sub-module, uart_rx_fifo: synchronous FWFT FIFO of width DATA_BITS+2 (data, parity_err, frame_err), parametrised by depth.
- Synchronizer, divider and FSM stay in the top module.

## Test plan
1. Defaults, send 0xA5 at 8680 ns/bit → rx_ready=1 within 1 bit time after the stop-bit start; data_out=0xA5, parity_err=0, frame_err=0. rd_en for 1 cycle → rx_ready=0.
2. PARITY=2, send 0x3C with parity bit 1 (correct is 0) → data_out=0x3C, parity_err=1. Then send 0x3C with parity bit 0 → parity_err=0.
3. Defaults, send 0x55 with stop bit 0, hold rx low 3 bit times, then high → exactly one word: 0x55, frame_err=1. No further words are pushed.
4. rx low pulse of 200 ns (10 clk) → no word, FSM back in IDLE; a following 0xA5 is received correctly.
5. FIFO_DEPTH=4, send 0x01..0x05 with no rd_en → overrun pulses exactly once. Four pops return 0x01, 0x02, 0x03, 0x04, then rx_ready=0.
6. Assert reset for 1 cycle after the 4th data bit of 0xA5 → all outputs 0 and no word pushed. Next frame 0x3C is received correctly.
